// File: rtl/inst_axi_bridge.sv
// inst_axi_bridge: turns the fetch stage's req/addr_ok/data_ok handshake into
// single-beat AXI4 reads, one transaction outstanding at a time.
module inst_axi_bridge #(
  parameter logic [3:0] AXI_ID = 4'd0,
  parameter int         ADDR_W = 32
) (
  input  logic              cpu_clk_50M,
  input  logic              cpu_rst_n,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [ADDR_W-1:0] inst_rdata,
  output logic              inst_bus_err,
  output logic              busy,
  output logic [3:0]        arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  input  logic [3:0]        rid,
  input  logic [ADDR_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready
);
  typedef enum logic [1:0] {IDLE, AR, R, RESP} state_e;
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] araddr_q, rdata_q;
  logic              err_q;
  logic              beat;
  logic              unused_ok;
  // Beats carrying a foreign id are consumed but never completed.
  assign beat         = (state_q == R) && rvalid && (rid == AXI_ID);
  assign inst_addr_ok = cpu_rst_n && (state_q == IDLE) && inst_req;
  assign inst_data_ok = (state_q == RESP);
  assign inst_bus_err = (state_q == RESP) && err_q;
  assign inst_rdata   = rdata_q;
  assign busy         = (state_q != IDLE);
  assign arid         = AXI_ID;
  assign araddr       = araddr_q;
  assign arlen        = 8'd0;
  assign arsize       = 3'b010;
  assign arburst      = 2'b01;
  assign arvalid      = (state_q == AR);
  assign rready       = (state_q == R);
  assign unused_ok    = ^{rlast, rresp[0]};
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q  <= IDLE;
      araddr_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (inst_addr_ok) araddr_q <= inst_addr;
      if (beat) begin
        rdata_q <= rdata;
        err_q   <= rresp[1];
      end
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = inst_req ? AR : IDLE;
      AR:      state_d = arready ? R : AR;
      R:       state_d = beat ? RESP : R;
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_inst_axi_bridge.sv
// tb_inst_axi_bridge: directed scenarios plus random traffic, checked every
// cycle against a transaction-level model of the bridge.
module tb_inst_axi_bridge;
  localparam logic [3:0] ID = 4'd0;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        inst_req = 1'b0, inst_addr_ok, inst_data_ok, inst_bus_err, busy;
  logic [31:0] inst_addr = '0, inst_rdata, araddr, rdata = '0;
  logic [3:0]  arid, rid = '0;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, rresp = '0;
  logic        arvalid, arready = 1'b0, rlast = 1'b1, rvalid = 1'b0, rready;
  int total = 0, bad = 0, hs = 0, ndone = 0;
  // transaction-level model: one open fetch with its progress flags
  logic        m_open = 0, m_ar = 0, m_beat = 0, m_err = 0, e_ok;
  logic [31:0] m_rdata = '0, m_addr = '0;

  inst_axi_bridge #(.AXI_ID(ID), .ADDR_W(32)) dut (
    .cpu_clk_50M(clk), .cpu_rst_n(rst_n), .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .inst_bus_err(inst_bus_err), .busy(busy), .arid(arid), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .arvalid(arvalid), .arready(arready), .rid(rid),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      m_open = 0; m_ar = 0; m_beat = 0; m_err = 0; m_rdata = '0; m_addr = '0;
    end
    e_ok = rst_n && !m_open && inst_req;
    chk("busy", busy, m_open);
    chk("addr_ok", inst_addr_ok, e_ok);
    chk("arvalid", arvalid, m_open && !m_ar);
    chk("rready", rready, m_open && m_ar && !m_beat);
    chk("data_ok", inst_data_ok, m_open && m_beat);
    chk("bus_err", inst_bus_err, m_open && m_beat && m_err);
    chk("inst_rdata", inst_rdata, m_rdata);
    chk("araddr", araddr, m_addr);
    chk("ar_const", {arid, arlen, arsize, arburst}, {ID, 8'd0, 3'b010, 2'b01});
    if (rst_n) begin
      if (arvalid && arready) hs++;
      if (e_ok) begin
        m_open = 1; m_ar = 0; m_beat = 0; m_addr = inst_addr;
      end else if (m_open && !m_ar) begin
        m_ar = arready;
      end else if (m_open && !m_beat) begin
        if (rvalid && rid == ID) begin
          m_beat = 1; m_rdata = rdata; m_err = rresp[1];
        end
      end else if (m_open) begin
        m_open = 0;
        ndone++;
      end
    end
  end

  task automatic fetch(input logic [31:0] a, input int arw, input int rw, input bit wrong,
                       input logic [31:0] d, input logic [1:0] resp);
    int n;
    inst_req = 1; inst_addr = a; arready = 0; rvalid = 0;
    n = 0;
    #1;
    while (!inst_addr_ok && n < 20) begin
      step(); #1; n++;
    end
    chk("accept", inst_addr_ok, 1);
    step();
    inst_req = 0;
    chk("f_araddr", araddr, a);
    chk("f_arlen_arsize", {arlen, arsize}, {8'd0, 3'd2});
    repeat (arw) begin
      chk("ar_hold_valid", arvalid, 1);
      chk("ar_hold_addr", araddr, a);
      step();
    end
    chk("ar_valid", arvalid, 1);
    arready = 1;
    step();
    arready = 0;
    chk("ar_drop", arvalid, 0);
    chk("r_ready", rready, 1);
    repeat (rw) step();
    rvalid = 1;
    if (wrong) begin
      rid = 4'h3; rdata = 32'hDEADBEEF; rresp = 0;
      step();
      chk("wrong_id_drop", {inst_data_ok, rready}, 2'b01);
    end
    rid = ID; rdata = d; rresp = resp;
    step();
    rvalid = 0; rdata = 32'hA5A5A5A5;
    chk("f_data_ok", inst_data_ok, 1);
    chk("f_rdata", inst_rdata, d);
    chk("f_bus_err", inst_bus_err, resp[1]);
    step();
    chk("f_pulse_end", {inst_data_ok, inst_bus_err, busy}, 3'b000);
    chk("f_rdata_hold", inst_rdata, d);
  endtask

  initial begin
    int nok, nd, hs0, ok;
    rid = ID;
    #1;
    chk("rst_outputs", {busy, arvalid, rready, inst_data_ok, inst_bus_err}, 5'b0);
    chk("rst_rdata", inst_rdata, 32'h0);
    repeat (3) step();
    rst_n = 1;
    step();
    fetch(32'h1FC00000, 0, 0, 0, 32'h3C08BFC0, 2'b00);
    hs0 = hs;
    fetch(32'h1FC00010, 5, 1, 0, 32'hCAFEF00D, 2'b00);
    chk("single_handshake", hs - hs0, 1);
    fetch(32'h1FC00020, 0, 4, 1, 32'h00000000, 2'b00);
    fetch(32'h1FC00030, 1, 0, 0, 32'h12345678, 2'b10);
    fetch(32'h1FC00034, 0, 2, 0, 32'h9ABCDEF0, 2'b00);
    inst_req = 1; inst_addr = 32'h1FC00000; arready = 1; rvalid = 1; rid = ID;
    rresp = 0; rdata = 32'h11111111; nok = 0; nd = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      chk("b2b_no_overlap", arvalid && rready, 0);
      if (inst_addr_ok) begin
        chk("b2b_ok_cycle", c, nok == 0 ? 0 : 4);
        nok++;
      end
      if (inst_data_ok) begin
        chk("b2b_rdata", inst_rdata, nd == 0 ? 32'h11111111 : 32'h22222222);
        nd++;
        rdata = 32'h22222222;
      end
      step();
      if (nok == 1) inst_addr = 32'h1FC00004;
      if (nok == 2) inst_req = 0;
    end
    chk("b2b_counts", {nok[15:0], nd[15:0]}, {16'd2, 16'd2});
    arready = 0; rvalid = 0;
    step();
    inst_req = 1; inst_addr = 32'h00400000; arready = 1;
    #1;
    chk("rst_t_accept", inst_addr_ok, 1);
    step();
    step();
    arready = 0;
    chk("rst_t_in_r", rready, 1);
    #2;
    rst_n = 0;
    #1;
    chk("async_rst_ctl", {busy, arvalid, rready, inst_data_ok, inst_bus_err, inst_addr_ok}, 6'b0);
    chk("async_rst_rdata", inst_rdata, 32'h0);
    chk("async_rst_araddr", araddr, 32'h0);
    rvalid = 1; rid = ID; rdata = 32'h55555555;
    step();
    step();
    rvalid = 0; inst_req = 0;
    rst_n = 1;
    nd = 0;
    repeat (5) begin
      step();
      if (inst_data_ok || busy) nd++;
    end
    chk("no_pulse_after_rst", nd, 0);
    fetch(32'h00400004, 0, 0, 0, 32'h24080001, 2'b00);
    hs0 = ndone;
    inst_req = 0;
    for (int c = 0; c < 3000; c++) begin
      arready = 1'($urandom_range(0, 1));
      rvalid = ($urandom_range(0, 2) != 0);
      rid = ($urandom_range(0, 3) == 0) ? 4'h3 : ID;
      rdata = $urandom;
      rresp = 2'($urandom_range(0, 3));
      if (!inst_req && $urandom_range(0, 1) == 1) begin
        inst_req = 1; inst_addr = $urandom & 32'hFFFFFFFC;
      end
      #1;
      ok = int'(inst_addr_ok);
      step();
      if (ok == 1) begin
        inst_req = 1'($urandom_range(0, 1));
        inst_addr = $urandom & 32'hFFFFFFFC;
      end
    end
    chk("rand_progress", (ndone - hs0) > 50, 1);
    inst_req = 0; arready = 0; rvalid = 0;
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
